// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: shares the game work-RAM port between the CPU and the
// hiscore engine. Pauses the CPU, waits a settle window, grants the port, and
// enforces a minimum CPU run window between grants.
// Optional build macro HISCORE_ARB_TIMEOUT_EN adds a grant-length limit with
// an hs_abort pulse and a re-arm requirement (hs_req must drop first).
module hiscore_ram_arbiter #(
   parameter int AW      = 10,
   parameter int DW      = 8,
   parameter int SETTLE  = 4,
   parameter int MIN_RUN = 16
`ifdef HISCORE_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 4096
`endif
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_dout,
   input  logic          cpu_we,
   output logic [DW-1:0] cpu_din,
   output logic          cpu_pause,
   input  logic          hs_req,
   input  logic [AW-1:0] hs_addr,
   input  logic [DW-1:0] hs_dout,
   input  logic          hs_we,
   output logic          hs_grant,
   output logic [DW-1:0] hs_din,
   output logic          hs_abort,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int RW = (MIN_RUN > 0) ? $clog2(MIN_RUN + 1) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [RW-1:0] RUN_MIN     = RW'(MIN_RUN);

   typedef enum logic [1:0] {IDLE, PAUSE, GRANT, RELEASE} state_t;

   state_t        state, state_next;
   logic [SW-1:0] settle_cnt;
   logic [RW-1:0] run_cnt, run_next;
   logic          owner_hs;
   logic          req_ok;
   logic          timeout_hit;

`ifdef HISCORE_ARB_TIMEOUT_EN
   localparam int GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [GW-1:0] GRANT_LAST = GW'(TIMEOUT - 1);

   logic [GW-1:0] grant_cnt;
   logic          rearm_block;

   assign timeout_hit = (state == GRANT) && (grant_cnt == GRANT_LAST);
   assign req_ok      = hs_req && !rearm_block;

   // Grant-length counter, abort pulse and re-arm lockout after a timeout
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_cnt   <= '0;
         rearm_block <= 1'b0;
         hs_abort    <= 1'b0;
      end else begin
         grant_cnt <= (state == GRANT) ? grant_cnt + 1'b1 : '0;
         hs_abort  <= timeout_hit;
         if (timeout_hit && hs_req)
            rearm_block <= 1'b1;
         else if (!hs_req)
            rearm_block <= 1'b0;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign req_ok      = hs_req;
   assign hs_abort    = 1'b0;
`endif

   // Next-state logic; run_next counts the current IDLE cycle so MIN_RUN
   // means exactly MIN_RUN unpaused CPU cycles between release and pause.
   always_comb begin
      state_next = state;
      run_next   = (run_cnt == RUN_MIN) ? run_cnt : run_cnt + 1'b1;
      case (state)
         IDLE:    if (req_ok && (run_next >= RUN_MIN)) state_next = PAUSE;
         PAUSE: begin
            if (!hs_req)                        state_next = RELEASE;
            else if (settle_cnt == SETTLE_LAST) state_next = GRANT;
         end
         GRANT:   if (timeout_hit || !hs_req) state_next = RELEASE;
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register with registered pause/grant/owner decoded from next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         run_cnt    <= '0;
         owner_hs   <= 1'b0;
         cpu_pause  <= 1'b0;
         hs_grant   <= 1'b0;
      end else begin
         state      <= state_next;
         cpu_pause  <= (state_next != IDLE);
         hs_grant   <= (state_next == GRANT);
         owner_hs   <= (state_next == GRANT);
         settle_cnt <= (state == PAUSE) ? settle_cnt + 1'b1 : '0;
         case (state)
            IDLE:    run_cnt <= run_next;
            RELEASE: run_cnt <= '0;
            default: run_cnt <= run_cnt;
         endcase
      end
   end

   assign ram_addr = owner_hs ? hs_addr : cpu_addr;
   assign ram_data = owner_hs ? hs_dout : cpu_dout;
   assign cpu_din  = ram_q;
   assign hs_din   = ram_q;

   // Write strobe: CPU in IDLE/PAUSE, hiscore only while granted, none in RELEASE
   always_comb begin
      ram_we = 1'b0;
      case (state)
         IDLE, PAUSE: ram_we = cpu_we;
         GRANT:       ram_we = hs_we && hs_grant;
         default:     ram_we = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: directed-vector bench with a behavioural
// synchronous RAM; expected values are hand-derived for SETTLE=4, MIN_RUN=16
// (and TIMEOUT=8 when HISCORE_ARB_TIMEOUT_EN is defined).
module tb_hiscore_ram_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_dout;
   logic          cpu_we;
   logic [DW-1:0] cpu_din;
   logic          cpu_pause;
   logic          hs_req;
   logic [AW-1:0] hs_addr;
   logic [DW-1:0] hs_dout;
   logic          hs_we;
   logic          hs_grant;
   logic [DW-1:0] hs_din;
   logic          hs_abort;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_we;
   logic [DW-1:0] ram_q;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int errors = 0;
   int checks = 0;
   int cnt;

   hiscore_ram_arbiter #(
      .AW(AW),
      .DW(DW),
      .SETTLE(4),
      .MIN_RUN(16)
`ifdef HISCORE_ARB_TIMEOUT_EN
      ,
      .TIMEOUT(8)
`endif
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
      .cpu_din(cpu_din), .cpu_pause(cpu_pause),
      .hs_req(hs_req), .hs_addr(hs_addr), .hs_dout(hs_dout), .hs_we(hs_we),
      .hs_grant(hs_grant), .hs_din(hs_din), .hs_abort(hs_abort),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Behavioural work RAM: synchronous write, 1-cycle read latency
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      reset_n = 1'b0;
      cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0;
      hs_req = 1'b0; hs_addr = '0; hs_dout = '0; hs_we = 1'b0;

      // Reset state
      nxt(); nxt(); smp();
      check("rst_pause", cpu_pause, 0);
      check("rst_grant", hs_grant, 0);
      check("rst_abort", hs_abort, 0);
      check("rst_ram_we", ram_we, 0);

      nxt();
      reset_n = 1'b1;
      repeat (20) nxt();

      // CPU write and read-back while CPU owns the port
      cpu_addr = 10'h00B; cpu_dout = 8'h5A; cpu_we = 1'b1;
      smp();
      check("cpu_wr_we", ram_we, 1);
      check("cpu_wr_addr", ram_addr, 10'h00B);
      check("cpu_wr_data", ram_data, 8'h5A);
      nxt();
      cpu_we = 1'b0;
      nxt();
      smp();
      check("cpu_rd", cpu_din, 8'h5A);

      // Grant latency: hs_req at cycle 0, pause at 1, grant at 5
      nxt();
      hs_req = 1'b1;
      smp();
      check("c0_pause", cpu_pause, 0);
      nxt();
      smp();
      check("c1_pause", cpu_pause, 1);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         nxt(); smp();
         if (hs_grant) cnt++;
      end
      check("settle_no_grant", cnt, 0);

      // Cycle 5: hiscore write passes, concurrent CPU write ignored
      nxt();
      hs_we = 1'b1; hs_addr = 10'h023; hs_dout = 8'h0F;
      cpu_we = 1'b1; cpu_addr = 10'h00B; cpu_dout = 8'hEE;
      smp();
      check("c5_grant", hs_grant, 1);
      check("hs_wr_we", ram_we, 1);
      check("hs_wr_addr", ram_addr, 10'h023);
      check("hs_wr_data", ram_data, 8'h0F);
      nxt();
      hs_we = 1'b0;
      smp();
      check("grant_cpu_we_ignored", ram_we, 0);
      nxt();
      cpu_we = 1'b0;
      hs_req = 1'b0;
      smp();
      check("hs_rd", hs_din, 8'h0F);

      // RELEASE turnaround: grant off, pause held, writes blocked
      nxt();
      cpu_we = 1'b1;
      smp();
      check("rel_grant", hs_grant, 0);
      check("rel_pause", cpu_pause, 1);
      check("rel_ram_we", ram_we, 0);

      // Back-to-back: 16 unpaused IDLE cycles, then pause
      nxt();
      cpu_we = 1'b0;
      hs_req = 1'b1;
      smp();
      check("mem_00B_kept", mem[10'h00B], 8'h5A);
      check("mem_023_written", mem[10'h023], 8'h0F);
      cnt = (cpu_pause == 1'b0) ? 1 : 0;
      for (int i = 0; i < 15; i++) begin
         nxt(); smp();
         if (cpu_pause == 1'b0) cnt++;
      end
      check("min_run_idle", cnt, 16);
      nxt(); smp();
      check("b2b_pause", cpu_pause, 1);

      // Drop hs_req at settle_cnt=1: no grant, pause falls two cycles later
      nxt();
      hs_req = 1'b0;
      smp();
      check("drop_s1_grant", hs_grant, 0);
      nxt(); smp();
      check("drop_rel_pause", cpu_pause, 1);
      check("drop_rel_grant", hs_grant, 0);
      nxt(); smp();
      check("drop_idle_pause", cpu_pause, 0);

      // Reset asserted mid-PAUSE at settle_cnt=2
      repeat (20) nxt();
      hs_req = 1'b1;
      nxt(); nxt(); nxt();
      smp();
      check("pre_rst_pause", cpu_pause, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_pause", cpu_pause, 0);
      check("async_rst_grant", hs_grant, 0);
      hs_req = 1'b0;
      nxt();
      reset_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         nxt(); smp();
         if (cpu_pause || hs_grant) cnt++;
      end
      check("post_rst_idle", cnt, 0);

      // Long-held request
      repeat (20) nxt();
      hs_req = 1'b1;
      repeat (5) nxt();
`ifdef HISCORE_ARB_TIMEOUT_EN
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         smp();
         if (hs_grant && !hs_abort) cnt++;
         nxt();
      end
      check("to_grant_cycles", cnt, 8);
      smp();
      check("to_grant_off", hs_grant, 0);
      check("to_abort", hs_abort, 1);
      nxt(); smp();
      check("to_abort_pulse", hs_abort, 0);
      check("to_pause_off", cpu_pause, 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         nxt(); smp();
         if (cpu_pause == 1'b0) cnt++;
      end
      check("to_no_regrant", cnt, 20);
      nxt();
      hs_req = 1'b0;
      nxt();
      hs_req = 1'b1;
      smp();
      check("rearm_pause_low", cpu_pause, 0);
      nxt(); smp();
      check("rearm_pause", cpu_pause, 1);
      hs_req = 1'b0;
      nxt(); nxt();
`else
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         smp();
         if (hs_grant && !hs_abort) cnt++;
         nxt();
      end
      check("hold_grant", cnt, 40);
      hs_req = 1'b0;
      nxt(); smp();
      check("hold_rel_grant", hs_grant, 0);
      nxt(); smp();
      check("hold_idle_pause", cpu_pause, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
